isp_awb_gain: RTL and testbench

ISP_AWB_GAIN -- requirements
Module: isp_awb_gain

---
 rtl/isp_awb_gain.sv | 205 ++++++++++++++++++++
 tb/tb_isp_awb_gain.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/isp_awb_gain.sv
// isp_awb_gain: gray-world auto white balance gain computation.
// Per-frame channel sums are turned into red and blue gains relative to green:
//   gain_r = floor((sum_g << GAIN_FRAC) / sum_r)
//   gain_b = floor((sum_g << GAIN_FRAC) / sum_b)
// Green gain is fixed at unity. One restoring divider runs twice, first for red
// and then for blue. Results saturate to the full-scale gain, and a zero divisor
// also gives full scale.
module isp_awb_gain #(
  parameter int OUT_BITS  = 32,
  parameter int GAIN_BITS = 8,
  parameter int GAIN_FRAC = 4
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [OUT_BITS-1:0]  min_cnt,
  input  logic                 in_done,
  input  logic [OUT_BITS-1:0]  in_cnt,
  input  logic [OUT_BITS-1:0]  in_sum_r,
  input  logic [OUT_BITS-1:0]  in_sum_g,
  input  logic [OUT_BITS-1:0]  in_sum_b,
  output logic [GAIN_BITS-1:0] out_gain_r,
  output logic [GAIN_BITS-1:0] out_gain_g,
  output logic [GAIN_BITS-1:0] out_gain_b,
  output logic                 out_valid,
  output logic                 busy
);

  // Dividend width: the shifted green sum never overflows.
  localparam int N     = OUT_BITS + GAIN_FRAC;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [GAIN_BITS-1:0] GAIN_ONE  = GAIN_BITS'(1) << GAIN_FRAC;
  localparam logic [GAIN_BITS-1:0] GAIN_MAX  = {GAIN_BITS{1'b1}};
  localparam logic [N-1:0]         QUO_MAX   = {{(N-GAIN_BITS){1'b0}}, GAIN_MAX};
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_R  = 2'd1,
    DIV_B  = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Clamp a full-width quotient to the gain range; a zero divisor reads as full scale.
  function automatic logic [GAIN_BITS-1:0] sat_gain(input logic [N-1:0] quo,
                                                    input logic       div_zero);
    logic [GAIN_BITS-1:0] g;
    if (div_zero) begin
      g = GAIN_MAX;
    end else if (quo > QUO_MAX) begin
      g = GAIN_MAX;
    end else begin
      g = quo[GAIN_BITS-1:0];
    end
    return g;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Dividend shift register; quotient bits enter at the LSB, so after N steps it holds the quotient.
  logic [N-1:0]         dvd_q, dvd_d;
  logic [OUT_BITS:0]    rem_q, rem_d;
  logic [N-1:0]         quo_r_q, quo_r_d;
  logic [OUT_BITS-1:0]  sum_r_q, sum_r_d;
  logic [OUT_BITS-1:0]  sum_g_q, sum_g_d;
  logic [OUT_BITS-1:0]  sum_b_q, sum_b_d;
  logic [GAIN_BITS-1:0] gain_r_q, gain_r_d;
  logic [GAIN_BITS-1:0] gain_g_q, gain_g_d;
  logic [GAIN_BITS-1:0] gain_b_q, gain_b_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [OUT_BITS-1:0]  divisor_s;
  logic [OUT_BITS:0]    rem_sh_s;
  logic [OUT_BITS:0]    rem_nx_s;
  logic                 qbit_s;
  logic [N-1:0]         dvd_nx_s;

  // One restoring-division step against the divisor of the current pass.
  always_comb begin
    divisor_s = sum_r_q;
    if (state_q == DIV_B) begin
      divisor_s = sum_b_q;
    end else begin
      divisor_s = sum_r_q;
    end
    rem_sh_s = {rem_q[OUT_BITS-1:0], dvd_q[N-1]};
    // A set top remainder bit means the true shifted value already exceeds any divisor.
    qbit_s   = rem_q[OUT_BITS] | (rem_sh_s >= {1'b0, divisor_s});
    if (qbit_s) begin
      rem_nx_s = rem_sh_s - {1'b0, divisor_s};
    end else begin
      rem_nx_s = rem_sh_s;
    end
    dvd_nx_s = {dvd_q[N-2:0], qbit_s};
  end

  // Sequencer: capture, two fixed-length division passes, then publish the gains.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    quo_r_d     = quo_r_q;
    sum_r_d     = sum_r_q;
    sum_g_d     = sum_g_q;
    sum_b_d     = sum_b_q;
    gain_r_d    = gain_r_q;
    gain_g_d    = gain_g_q;
    gain_b_d    = gain_b_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_done && enable && (in_cnt >= min_cnt)) begin
          sum_r_d = in_sum_r;
          sum_g_d = in_sum_g;
          sum_b_d = in_sum_b;
          dvd_d   = {in_sum_g, {GAIN_FRAC{1'b0}}};
          rem_d   = {(OUT_BITS+1){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = DIV_R;
        end else begin
          state_d = IDLE;
        end
      end
      DIV_R: begin
        dvd_d = dvd_nx_s;
        rem_d = rem_nx_s;
        if (cnt_q == CNT_LAST) begin
          // Red quotient done; reload the same dividend for the blue pass.
          quo_r_d = dvd_nx_s;
          dvd_d   = {sum_g_q, {GAIN_FRAC{1'b0}}};
          rem_d   = {(OUT_BITS+1){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = DIV_B;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV_B: begin
        dvd_d = dvd_nx_s;
        rem_d = rem_nx_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      UPDATE: begin
        // The blue quotient is still sitting in the dividend register.
        gain_r_d    = sat_gain(quo_r_q, (sum_r_q == {OUT_BITS{1'b0}}));
        gain_b_d    = sat_gain(dvd_q, (sum_b_q == {OUT_BITS{1'b0}}));
        gain_g_d    = GAIN_ONE;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset abandons any computation in flight.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      dvd_q       <= {N{1'b0}};
      rem_q       <= {(OUT_BITS+1){1'b0}};
      quo_r_q     <= {N{1'b0}};
      sum_r_q     <= {OUT_BITS{1'b0}};
      sum_g_q     <= {OUT_BITS{1'b0}};
      sum_b_q     <= {OUT_BITS{1'b0}};
      gain_r_q    <= GAIN_ONE;
      gain_g_q    <= GAIN_ONE;
      gain_b_q    <= GAIN_ONE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      quo_r_q     <= quo_r_d;
      sum_r_q     <= sum_r_d;
      sum_g_q     <= sum_g_d;
      sum_b_q     <= sum_b_d;
      gain_r_q    <= gain_r_d;
      gain_g_q    <= gain_g_d;
      gain_b_q    <= gain_b_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign out_gain_r = gain_r_q;
  assign out_gain_g = gain_g_q;
  assign out_gain_b = gain_b_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_isp_awb_gain.sv
// Directed bench for isp_awb_gain with hand-computed gains and latency.
module tb_isp_awb_gain;

  logic        pclk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] min_cnt;
  logic        in_done;
  logic [31:0] in_cnt, in_sum_r, in_sum_g, in_sum_b;
  logic [7:0]  out_gain_r, out_gain_g, out_gain_b;
  logic        out_valid, busy;

  int n_chk  = 0;
  int n_pass = 0;

  int first_v, nv, nbusy, nchg;

  always #5 pclk = ~pclk;

  isp_awb_gain dut (
    .pclk       (pclk),
    .rst        (rst),
    .enable     (enable),
    .min_cnt    (min_cnt),
    .in_done    (in_done),
    .in_cnt     (in_cnt),
    .in_sum_r   (in_sum_r),
    .in_sum_g   (in_sum_g),
    .in_sum_b   (in_sum_b),
    .out_gain_r (out_gain_r),
    .out_gain_g (out_gain_g),
    .out_gain_b (out_gain_b),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  // Present one frame of statistics for one cycle, then scramble the inputs.
  task automatic send(input logic [31:0] cnt, input logic [31:0] r, input logic [31:0] g,
                      input logic [31:0] b, input logic en, input logic drop_en);
    @(posedge pclk); #1;
    enable   = en;
    in_cnt   = cnt;
    in_sum_r = r;
    in_sum_g = g;
    in_sum_b = b;
    in_done  = 1'b1;
    @(posedge pclk); #1;
    in_done  = 1'b0;
    in_cnt   = $urandom;
    in_sum_r = $urandom;
    in_sum_g = $urandom;
    in_sum_b = $urandom;
    if (drop_en) enable = 1'b0;
  endtask

  // Observe ncyc cycles after the capture edge; optionally inject a second
  // frame (saturating sums) or a one-cycle reset pulse at a given cycle.
  task automatic watch(input int ncyc, input int inj_at, input int rst_at,
                       output int fv, output int nvo, output int nb, output int nc);
    logic [7:0] pr, pg, pb;
    pr = out_gain_r; pg = out_gain_g; pb = out_gain_b;
    fv = 0; nvo = 0; nb = 0; nc = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge pclk); #1;
      if (in_done) in_done = 1'b0;
      if (rst) rst = 1'b0;
      if (out_valid) begin
        nvo++;
        if (fv == 0) fv = i;
      end
      if (busy) nb++;
      if (!out_valid && rst_at == 0 &&
          (out_gain_r != pr || out_gain_g != pg || out_gain_b != pb)) nc++;
      pr = out_gain_r; pg = out_gain_g; pb = out_gain_b;
      if (i == inj_at) begin
        enable   = 1'b1;
        in_cnt   = 32'd1000;
        in_sum_r = 32'd1000;
        in_sum_g = 32'd1000000;
        in_sum_b = 32'd0;
        in_done  = 1'b1;
      end
      if (i == rst_at) rst = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; min_cnt = 32'd100; in_done = 1'b0;
    in_cnt = '0; in_sum_r = '0; in_sum_g = '0; in_sum_b = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_gain_r", out_gain_r, 16);
    chk("rst_gain_g", out_gain_g, 16);
    chk("rst_gain_b", out_gain_b, 16);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Nominal, with enable dropped and inputs scrambled after capture.
    send(32'd1000, 32'd100000, 32'd200000, 32'd50000, 1'b1, 1'b1);
    chk("nom_busy", busy, 1);
    watch(80, 0, 0, first_v, nv, nbusy, nchg);
    enable = 1'b1;
    chk("nom_latency", first_v, 73);
    chk("nom_nvalid", nv, 1);
    chk("nom_hold", nchg, 0);
    chk("nom_gain_r", out_gain_r, 32);
    chk("nom_gain_g", out_gain_g, 16);
    chk("nom_gain_b", out_gain_b, 64);

    // Saturation and divide-by-zero.
    send(32'd1000, 32'd1000, 32'd1000000, 32'd0, 1'b1, 1'b0);
    watch(80, 0, 0, first_v, nv, nbusy, nchg);
    chk("sat_latency", first_v, 73);
    chk("sat_gain_r", out_gain_r, 255);
    chk("sat_gain_b", out_gain_b, 255);
    chk("sat_gain_g", out_gain_g, 16);

    // Truncation: 160/3 = 53, 160/10 = 16.
    send(32'd1000, 32'd3, 32'd10, 32'd10, 1'b1, 1'b0);
    watch(80, 0, 0, first_v, nv, nbusy, nchg);
    chk("trunc_gain_r", out_gain_r, 53);
    chk("trunc_gain_b", out_gain_b, 16);

    // Pixel count below threshold.
    send(32'd99, 32'd100000, 32'd200000, 32'd50000, 1'b1, 1'b0);
    chk("low_busy", busy, 0);
    watch(80, 0, 0, first_v, nv, nbusy, nchg);
    chk("low_nvalid", nv, 0);
    chk("low_nbusy", nbusy, 0);
    chk("low_gain_r", out_gain_r, 53);
    chk("low_gain_b", out_gain_b, 16);

    // Statistics presented while disabled.
    send(32'd1000, 32'd100000, 32'd200000, 32'd50000, 1'b0, 1'b0);
    chk("dis_busy", busy, 0);
    watch(80, 0, 0, first_v, nv, nbusy, nchg);
    enable = 1'b1;
    chk("dis_nvalid", nv, 0);
    chk("dis_nbusy", nbusy, 0);
    chk("dis_gain_r", out_gain_r, 53);
    chk("dis_gain_b", out_gain_b, 16);

    // Second frame arriving while busy must be dropped.
    send(32'd1000, 32'd100000, 32'd200000, 32'd50000, 1'b1, 1'b0);
    watch(160, 10, 0, first_v, nv, nbusy, nchg);
    chk("ovl_latency", first_v, 73);
    chk("ovl_nvalid", nv, 1);
    chk("ovl_gain_r", out_gain_r, 32);
    chk("ovl_gain_b", out_gain_b, 64);

    // Reset in the middle of a computation.
    send(32'd1000, 32'd1000, 32'd1000000, 32'd0, 1'b1, 1'b0);
    watch(120, 0, 40, first_v, nv, nbusy, nchg);
    chk("mrst_nvalid", nv, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_gain_r", out_gain_r, 16);
    chk("mrst_gain_g", out_gain_g, 16);
    chk("mrst_gain_b", out_gain_b, 16);

    // Fresh computation after reset.
    send(32'd1000, 32'd3, 32'd10, 32'd10, 1'b1, 1'b0);
    watch(80, 0, 0, first_v, nv, nbusy, nchg);
    chk("fresh_latency", first_v, 73);
    chk("fresh_nvalid", nv, 1);
    chk("fresh_gain_r", out_gain_r, 53);
    chk("fresh_gain_b", out_gain_b, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
